// File: rtl/spi_frame_master.sv
// spi_frame_master
//
// SPI master for the ILI9341 display path. Words arrive on a valid/ready
// stream, go out MSB-first on mosi, and the bits seen on miso during the
// same transfer are assembled into rx_data. sclk runs at clk/(2*CLK_DIV)
// with selectable CPOL/CPHA. cs_n stays low across a burst and is only
// released after the word tagged tx_last, followed by a CS_IDLE-cycle gap.
//
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   tx_data/tx_dc/      : word, D/CX value and end-of-frame flag,
//   tx_last             :   captured on the handshake only
//   tx_valid/tx_ready   : input stream handshake
//   rx_data/rx_valid    : captured miso word and its one-cycle strobe
//   done                : one-cycle pulse as cs_n rises at frame end
//   busy                : high whenever the engine is not idle
//   sclk/mosi/miso/cs_n : SPI bus
//   dc                  : display D/CX line
module spi_frame_master #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2,
  parameter bit CPOL    = 1'b0,
  parameter bit CPHA    = 1'b0,
  parameter int CS_IDLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_dc,
  input  logic              tx_last,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              done,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n,
  output logic              dc
);

  // Counter widths are kept at least one bit wide so CLK_DIV=1 and
  // CS_IDLE=1 still produce legal vectors.
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam int GAP_W  = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;

  localparam logic [DIV_W-1:0]  DIV_MAX         = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_TOTAL      = EDGE_W'(2 * DATA_W);
  localparam logic [EDGE_W-1:0] EDGE_LAST_TRAIL = EDGE_W'(2 * DATA_W - 1);
  localparam logic [GAP_W-1:0]  GAP_MAX         = GAP_W'(CS_IDLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    WAIT,
    GAP
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                done_q, done_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                cs_n_q, cs_n_d;
  logic                dc_q, dc_d;
  logic                last_q, last_d;

  logic                div_last;
  logic                toggle;
  logic                leading;
  logic                sample_now;
  logic                drive_now;

  // Only these two outputs decode the state directly; everything else is
  // a flop so the bus pins never glitch.
  assign tx_ready = ((state_q == IDLE) || (state_q == WAIT)) && !rst;
  assign busy     = (state_q != IDLE);
  assign div_last = (div_q == DIV_MAX);

  // Next-state logic. The SETUP->SHIFT transition itself produces the first
  // sclk edge, and SHIFT keeps running one more divider period after the
  // last edge so the captured word is presented exactly as HOLD begins.
  always_comb begin
    state_d    = state_q;
    div_d      = div_last ? '0 : div_q + 1'b1;
    edge_cnt_d = edge_cnt_q;
    gap_d      = gap_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    done_d     = 1'b0;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    dc_d       = dc_q;
    last_d     = last_q;
    toggle     = 1'b0;

    case (state_q)
      IDLE, WAIT: begin
        if (tx_valid && tx_ready) begin
          // With CPHA=0 the first bit must already sit on mosi before the
          // first (sampling) edge; with CPHA=1 the first leading edge drives it.
          if (CPHA) begin
            tx_sr_d = tx_data;
          end else begin
            tx_sr_d = {tx_data[DATA_W-2:0], 1'b0};
            mosi_d  = tx_data[DATA_W-1];
          end
          dc_d       = tx_dc;
          last_d     = tx_last;
          cs_n_d     = 1'b0;
          sclk_d     = CPOL;
          edge_cnt_d = '0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (div_last) begin
          state_d = SHIFT;
          toggle  = 1'b1;
        end
      end
      SHIFT: begin
        if (div_last) begin
          if (edge_cnt_q == EDGE_TOTAL) begin
            state_d    = HOLD;
            rx_data_d  = rx_sr_q;
            rx_valid_d = 1'b1;
          end else begin
            toggle = 1'b1;
          end
        end
      end
      HOLD: begin
        if (div_last) begin
          if (last_q) begin
            state_d = GAP;
            cs_n_d  = 1'b1;
            done_d  = 1'b1;
            gap_d   = '0;
          end else begin
            state_d = WAIT;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_MAX) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Odd-numbered edges (edge count still even) are leading edges. The
    // final trailing edge with CPHA=0 leaves mosi on the last bit.
    leading    = ~edge_cnt_q[0];
    sample_now = toggle && (CPHA ? !leading : leading);
    drive_now  = toggle && (CPHA ? leading
                                 : (!leading && (edge_cnt_q != EDGE_LAST_TRAIL)));

    if (toggle) begin
      sclk_d     = ~sclk_q;
      edge_cnt_d = edge_cnt_q + 1'b1;
    end
    if (sample_now) begin
      rx_sr_d = {rx_sr_q[DATA_W-2:0], miso};
    end
    if (drive_now) begin
      mosi_d  = tx_sr_q[DATA_W-1];
      tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
    end

    // The divider restarts on every state change so each state's dwell
    // time is counted from zero.
    if (state_d != state_q) begin
      div_d = '0;
    end
  end

  // State and output registers. Reset abandons any word in flight without
  // emitting rx_valid or done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      edge_cnt_q <= '0;
      gap_q      <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      sclk_q     <= CPOL;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      dc_q       <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      edge_cnt_q <= edge_cnt_d;
      gap_q      <= gap_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      done_q     <= done_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      dc_q       <= dc_d;
      last_q     <= last_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign done     = done_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;
  assign dc       = dc_q;

endmodule

// File: doc/spi_frame_master.md
# spi_frame_master

Parametrised SPI master for the ILI9341 display path. It accepts words over a valid/ready stream and serialises them MSB-first on MOSI, capturing MISO into a read-back word. It drives SCLK at a programmable divided rate with selectable CPOL/CPHA, and drives the display's D/CX line and chip select. Multi-word bursts keep `cs_n` low between words, and CS is released only after a word tagged `tx_last`.

## Interface
- `DATA_W`, 8: bits per word; legal 2..32.
- `CLK_DIV`, 2: `clk` cycles per SCLK half period; legal ≥1.
- `CPOL`, 0: SCLK idle level.
- `CPHA`, 0: 0 = sample on the leading edge, shift on trailing; 1 = shift on leading, sample on trailing.
- `CS_IDLE`, 2: minimum `clk` cycles `cs_n` stays high between frames; legal ≥1.

Ports:
- `clk` in 1: sole clock; all logic on posedge.
- `rst` in 1: reset, synchronous and active-high.
- `tx_data` in DATA_W: word to send.
- `tx_dc` in 1: D/CX value for this word (0 = command, 1 = data).
- `tx_last` in 1: deassert `cs_n` after this word.
- `tx_valid` in 1: word present.
- `tx_ready` out 1: word accepted when `tx_valid && tx_ready` at posedge.
- `rx_data` out DATA_W: MISO word captured during the previous transfer; held until the next capture.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `done` out 1: one-cycle pulse when a frame ends (`cs_n` rising).
- `busy` out 1: high in every state except IDLE.
- `sclk` out 1; `mosi` out 1; `miso` in 1; `cs_n` out 1; `dc` out 1.

## Operation
- States: IDLE, SETUP, SHIFT, HOLD, WAIT, GAP.
- **Reset:** the posedge with `rst=1` forces:
  - state IDLE, `cs_n=1`, `sclk=CPOL`, `mosi=0`, `dc=0`;
  - `rx_data=0`, `rx_valid=0`, `done=0`;
  - `tx_ready=0` while `rst` is high.
  
  This applies mid-transfer as well. The word in flight is dropped and no `rx_valid` or `done` pulse is issued.
- **`tx_ready`:** equals (state==IDLE || state==WAIT) && !rst.
- **Handshake in IDLE or WAIT:**
  - load `tx_data` into the shift register and register `tx_dc` to `dc` and `tx_last` to `last_q`;
  - drive `cs_n=0` and `mosi` = bit DATA_W-1 (when CPHA=0);
  - enter SETUP.
- **SETUP:** lasts CLK_DIV cycles with `sclk` idle, then enters SHIFT.
- **SHIFT:** `sclk` toggles once every CLK_DIV cycles, 2·DATA_W toggles in total; the final toggle returns `sclk` to CPOL.
  - CPHA=0: leading edge samples `miso`; trailing edge advances `mosi` to the next bit (the final trailing edge leaves `mosi` unchanged).
  - CPHA=1: leading edge drives the next bit (the first leading edge drives bit DATA_W-1); trailing edge samples `miso`.
  - Sampled bits shift in at the LSB. After DATA_W samples, the complete word is copied to `rx_data` and `rx_valid` pulses in the first HOLD cycle.
- **HOLD:** CLK_DIV cycles with `sclk` idle and `cs_n` low. Then:
  - if `last_q=1`: go to GAP, `cs_n` rises, and `done` pulses in the first GAP cycle;
  - otherwise: go to WAIT.
- **WAIT:** `cs_n` stays low, `sclk` idle, `tx_ready=1`, with no timeout. A dropped `tx_valid` leaves the frame open indefinitely.
- **GAP:** `cs_n=1` for CS_IDLE cycles, `tx_ready=0`, then IDLE. `tx_valid` presented during GAP is held off, not lost.
- **Registered state:** `dc` changes only on handshake; `tx_data`, `tx_dc` and `tx_last` are ignored outside the handshake.
- **Counters:**
  - divider: $clog2(CLK_DIV) bits, cleared on every state change, wraps at CLK_DIV-1;
  - edge counter: $clog2(2·DATA_W+1) bits; no overflow is reachable.

## Timing
- All outputs are registered except `tx_ready` and `busy`, which decode the state.
- Handshake at edge 0: `cs_n`, `dc` and `mosi` are valid from cycle 1. The first SCLK edge is at cycle CLK_DIV+1, and edges follow every CLK_DIV cycles.
- Per-word latency from handshake to `rx_valid` = CLK_DIV·(2·DATA_W+1)+1 cycles.
- Back-to-back burst with `tx_valid` held high: word period = CLK_DIV·(2·DATA_W+2)+1 cycles. With the defaults this is 37.
- Frame end: `done` fires CLK_DIV·(2·DATA_W+2)+1 cycles after the last word's handshake. The next handshake comes no earlier than CS_IDLE+1 cycles later.
- Minimum `cs_n`-low-to-first-edge and last-edge-to-`cs_n`-high = CLK_DIV cycles each.

## Test plan
- Defaults, single word 0xA5, `tx_last=1`, `tx_dc=0`, `miso` looped to `mosi`:
  - 8 rising SCLK edges and MOSI bits 1,0,1,0,0,1,0,1;
  - `dc=0` throughout, `rx_data=0xA5`;
  - `rx_valid` at cycle 35 and `done` at cycle 37;
  - `cs_n` high for 2 cycles after `done`.
- Burst 0x2C(dc=0), 0x12(dc=1), 0x34(dc=1, last):
  - `cs_n` stays low across all 3 words;
  - `dc` changes only at handshakes;
  - word period 37 cycles and one `done`.
- CPOL=1, CPHA=1, CLK_DIV=1, DATA_W=16, word 0x8001:
  - `sclk` idles high, MOSI changes on falling edges;
  - 32 toggles, then period 35 cycles;
  - `rx_data` equals the MISO pattern 0xF00F driven by the bench.
- Burst word 1 with `last=0`, then `tx_valid` low for 50 cycles: state is WAIT with `cs_n=0` and `tx_ready=1`. Word 2 with `last=1` then completes normally.
- `rst` pulsed at SCLK edge 5 of a word: next cycle `cs_n=1`, `sclk=CPOL`, no `rx_valid` or `done`; a subsequent word transfers correctly.
- `tx_valid` held high through GAP: `tx_ready` stays 0 for CS_IDLE cycles. The new handshake occurs in the first IDLE cycle and no word is lost or duplicated.
